ex_div_ctrl: RTL

//  Sequencer for the EX-stage RV32M DIV/DIVU/REM/REMU operations, built around an

---
 rtl/ex_div_ctrl_pkg.sv | 47 ++++
 rtl/ex_div_ctrl_if.sv | 27 ++
 rtl/ex_div_ctrl_chk.sv | 16 +
 rtl/ex_div_ctrl_div_step.sv | 22 ++
 rtl/ex_div_ctrl.sv | 118 +++++++++++
 5 files changed

// File: rtl/ex_div_ctrl_pkg.sv
// Shared types and constants for the EX-stage divide sequencer.
package ex_div_ctrl_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  // Divider sequencer states
  typedef enum logic [1:0] {
    DivIdle   = 2'd0,
    DivByZero = 2'd1,
    DivRun    = 2'd2,
    DivDone   = 2'd3
  } div_state_e;

  localparam logic            DivResultReady    = 1'b1;
  localparam logic            DivResultNotReady = 1'b0;
  localparam logic            StallReq          = 1'b1;
  localparam logic            NoStall           = 1'b0;
  localparam logic [XLEN-1:0] ZeroWord          = 32'h0000_0000;
  localparam logic [XLEN-1:0] AllOnesWord       = 32'hFFFF_FFFF;
  localparam logic [CNT_W-1:0] LastStep         = 6'd31;

  // Two's complement magnitude of a value when it is treated as signed
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] val,
                                              input logic            sgn);
    logic [XLEN-1:0] res;
    if (sgn && val[XLEN-1]) begin
      res = ZeroWord - val;
    end else begin
      res = val;
    end
    return res;
  endfunction

  // Conditional two's complement negation used for sign correction
  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] val,
                                             input logic            neg);
    logic [XLEN-1:0] res;
    if (neg) begin
      res = ZeroWord - val;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/ex_div_ctrl_if.sv
// EX <-> divider handshake and operand bus.
interface ex_div_ctrl_if;
  import ex_div_ctrl_pkg::*;

  logic            start_i;
  logic            annul_i;
  logic            signed_i;
  logic            rem_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic [XLEN-1:0] result_o;
  logic            ready_o;
  logic            stallreq_o;

  // EX stage side
  modport master (
    output start_i, annul_i, signed_i, rem_i, dividend_i, divisor_i,
    input  result_o, ready_o, stallreq_o
  );

  // Divider side
  modport slave (
    input  start_i, annul_i, signed_i, rem_i, dividend_i, divisor_i,
    output result_o, ready_o, stallreq_o
  );

endinterface

// File: rtl/ex_div_ctrl_chk.sv
// Protocol checks for the divide sequencer.
module ex_div_ctrl_chk
  import ex_div_ctrl_pkg::*;
(
  input logic       clk,
  input logic       rst,
  input div_state_e state,
  input logic       start_i,
  input logic       annul_i
);

  // EX must keep start_i high while an operation is in flight unless it annuls
  a_start_held: assert property (@(posedge clk) disable iff (!rst)
    ((state == DivRun) || (state == DivByZero)) |-> (start_i || annul_i));

endmodule

// File: rtl/ex_div_ctrl_div_step.sv
// One combinational radix-2 restoring division step.
module div_step
  import ex_div_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] dq_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] dq_out
);

  logic [XLEN:0] shifted_s;
  logic [XLEN:0] diff_s;

  // The shifted partial remainder keeps the full remainder word so divisors
  // above 2^(XLEN-1) still compare correctly; the borrow bit is the compare.
  assign shifted_s = {rem_in, dq_in[XLEN-1]};
  assign diff_s    = shifted_s - {1'b0, divisor};
  assign rem_out   = diff_s[XLEN] ? shifted_s[XLEN-1:0] : diff_s[XLEN-1:0];
  assign dq_out    = {dq_in[XLEN-2:0], ~diff_s[XLEN]};

endmodule

// File: rtl/ex_div_ctrl.sv
// EX-stage RV32M divide sequencer around an iterative restoring divider.
module ex_div_ctrl
  import ex_div_ctrl_pkg::*;
(
  input logic          clk,
  input logic          rst,
  ex_div_ctrl_if.slave bus
);

  div_state_e      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] dq_r;
  logic [XLEN-1:0] divisor_r;
  logic [XLEN-1:0] dividend_raw_r;
  logic            neg_q_r;
  logic            neg_r_r;
  logic            rem_sel_r;
  logic [XLEN-1:0] result_r;
  logic            ready_r;

  logic [XLEN-1:0] step_rem_s;
  logic [XLEN-1:0] step_dq_s;

  div_step u_step (
    .rem_in  (rem_r),
    .dq_in   (dq_r),
    .divisor (divisor_r),
    .rem_out (step_rem_s),
    .dq_out  (step_dq_s)
  );

  ex_div_ctrl_chk u_chk (
    .clk     (clk),
    .rst     (rst),
    .state   (state_r),
    .start_i (bus.start_i),
    .annul_i (bus.annul_i)
  );

  // Stall EX while a request is pending and no result is being delivered
  assign bus.stallreq_o = (bus.start_i && !bus.annul_i && (state_r != DivDone)) ? StallReq : NoStall;
  assign bus.result_o   = result_r;
  assign bus.ready_o    = ready_r;

  // Sequencer FSM, iteration datapath and registered result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= DivIdle;
      cnt_r          <= 6'd0;
      rem_r          <= ZeroWord;
      dq_r           <= ZeroWord;
      divisor_r      <= ZeroWord;
      dividend_raw_r <= ZeroWord;
      neg_q_r        <= 1'b0;
      neg_r_r        <= 1'b0;
      rem_sel_r      <= 1'b0;
      result_r       <= ZeroWord;
      ready_r        <= DivResultNotReady;
    end else if (bus.annul_i) begin
      state_r  <= DivIdle;
      result_r <= ZeroWord;
      ready_r  <= DivResultNotReady;
    end else begin
      case (state_r)
        DivIdle: begin
          if (bus.start_i) begin
            rem_sel_r      <= bus.rem_i;
            dividend_raw_r <= bus.dividend_i;
            rem_r          <= ZeroWord;
            dq_r           <= abs_val(bus.dividend_i, bus.signed_i);
            divisor_r      <= abs_val(bus.divisor_i, bus.signed_i);
            neg_q_r        <= bus.signed_i & (bus.dividend_i[XLEN-1] ^ bus.divisor_i[XLEN-1]);
            neg_r_r        <= bus.signed_i & bus.dividend_i[XLEN-1];
            cnt_r          <= 6'd0;
            if (bus.divisor_i == ZeroWord) begin
              state_r <= DivByZero;
            end else begin
              state_r <= DivRun;
            end
          end else begin
            state_r <= DivIdle;
          end
        end
        DivByZero: begin
          result_r <= rem_sel_r ? dividend_raw_r : AllOnesWord;
          ready_r  <= DivResultReady;
          state_r  <= DivDone;
        end
        DivRun: begin
          rem_r <= step_rem_s;
          dq_r  <= step_dq_s;
          cnt_r <= cnt_r + 6'd1;
          if (cnt_r == LastStep) begin
            result_r <= rem_sel_r ? neg_if(step_rem_s, neg_r_r) : neg_if(step_dq_s, neg_q_r);
            ready_r  <= DivResultReady;
            state_r  <= DivDone;
          end else begin
            state_r <= DivRun;
          end
        end
        DivDone: begin
          if (!bus.start_i) begin
            ready_r <= DivResultNotReady;
            state_r <= DivIdle;
          end else begin
            state_r <= DivDone;
          end
        end
        default: begin
          state_r <= DivIdle;
          ready_r <= DivResultNotReady;
        end
      endcase
    end
  end

endmodule
